// File: rtl/spi_arbiter_if.sv
// Bus bundle between the I/O register decode, the SPI arbiter and the shared SPI engine.
// master: the arbiter's view; slave: the requester/engine side.
interface spi_arbiter_if;
  logic [1:0]  req;
  logic [1:0]  xfer;
  logic [1:0]  fast;
  logic [31:0] tx0;
  logic [31:0] tx1;
  logic [1:0]  gnt;
  logic [1:0]  done;
  logic [31:0] rx;
  logic [1:0]  err;
  logic [1:0]  cs_n;
  logic        spi_start;
  logic        spi_fast;
  logic [31:0] spi_tx;
  logic        spi_rdy;
  logic [31:0] spi_rx;

  modport master (
    input  req, xfer, fast, tx0, tx1, spi_rdy, spi_rx,
    output gnt, done, rx, err, cs_n, spi_start, spi_fast, spi_tx
  );

  modport slave (
    output req, xfer, fast, tx0, tx1, spi_rdy, spi_rx,
    input  gnt, done, rx, err, cs_n, spi_start, spi_fast, spi_tx
  );
endinterface

// File: rtl/spi_arbiter.sv
// Two-requester arbiter for one SPI engine: round-robin per burst, owns chip selects and CS setup/hold.
// Optional idle-grant watchdog enabled by defining SPI_ARB_WDOG_EN.
module spi_arbiter #(
  parameter int CS_SETUP    = 4,
  parameter int CS_HOLD     = 4,
  parameter int WDOG_CYCLES = 1024
) (
  input  logic          clk,
  input  logic          rst,
  spi_arbiter_if.master bus
);

  typedef enum logic [2:0] {
    IDLE, SETUP, READY, LAUNCH, ARM, BUSY, HOLD, GAP
  } state_t;

  localparam logic [7:0] SETUP_LAST = 8'(CS_SETUP);
  localparam logic [7:0] HOLD_LAST  = 8'(CS_HOLD);

  state_t      state_reg, state_next;
  logic [7:0]  cnt_reg, cnt_next;
  logic        owner_reg, owner_next;
  logic        pri_reg, pri_next;
  logic [1:0]  done_reg, done_next;
  logic [1:0]  err_reg, err_next;
  logic [31:0] rx_reg, rx_next;
  logic [31:0] tx_reg, tx_next;
  logic        fast_reg, fast_next;
  logic [1:0]  req_ok;
  logic        gnt_active;
  logic        cs_active;

`ifdef SPI_ARB_WDOG_EN
  localparam logic [31:0] WDOG_LAST = 32'(WDOG_CYCLES - 1);
  logic [31:0] wdog_reg, wdog_next;
  logic [1:0]  block_reg, block_next;
  logic        wdog_hit;

  // A revoked owner stays locked out until it lets go of req.
  assign req_ok   = bus.req & ~block_reg;
  assign wdog_hit = (wdog_reg == WDOG_LAST);
`else
  logic unused_wdog_cfg;
  assign unused_wdog_cfg = (WDOG_CYCLES != 0);
  assign req_ok          = bus.req;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= IDLE;
      cnt_reg   <= '0;
      owner_reg <= 1'b0;
      pri_reg   <= 1'b0;
      done_reg  <= '0;
      err_reg   <= '0;
      rx_reg    <= '0;
      tx_reg    <= '0;
      fast_reg  <= 1'b0;
`ifdef SPI_ARB_WDOG_EN
      wdog_reg  <= '0;
      block_reg <= '0;
`endif
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      owner_reg <= owner_next;
      pri_reg   <= pri_next;
      done_reg  <= done_next;
      err_reg   <= err_next;
      rx_reg    <= rx_next;
      tx_reg    <= tx_next;
      fast_reg  <= fast_next;
`ifdef SPI_ARB_WDOG_EN
      wdog_reg  <= wdog_next;
      block_reg <= block_next;
`endif
    end
  end

  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    owner_next = owner_reg;
    pri_next   = pri_reg;
    done_next  = 2'b00;
    err_next   = 2'b00;
    rx_next    = rx_reg;
    tx_next    = tx_reg;
    fast_next  = fast_reg;
`ifdef SPI_ARB_WDOG_EN
    wdog_next  = (state_reg == READY) ? wdog_reg + 32'd1 : 32'd0;
    block_next = block_reg & bus.req;
`endif
    case (state_reg)
      IDLE: begin
        if (|req_ok) begin
          owner_next = (req_ok == 2'b11) ? pri_reg : req_ok[1];
          cnt_next   = '0;
          state_next = SETUP;
        end
      end
      SETUP: begin
        if (cnt_reg == SETUP_LAST) state_next = READY;
        else cnt_next = cnt_reg + 8'd1;
      end
      READY: begin
        // A launch wins over a release seen in the same cycle.
        if (bus.xfer[owner_reg]) begin
          tx_next    = owner_reg ? bus.tx1 : bus.tx0;
          fast_next  = bus.fast[owner_reg];
          state_next = LAUNCH;
        end else if (!bus.req[owner_reg]) begin
          cnt_next   = '0;
          state_next = HOLD;
`ifdef SPI_ARB_WDOG_EN
        end else if (wdog_hit) begin
          err_next[owner_reg]   = 1'b1;
          block_next[owner_reg] = 1'b1;
          cnt_next              = '0;
          state_next            = HOLD;
`endif
        end
      end
      LAUNCH: state_next = ARM;
      // The engine only drops rdy the cycle after start, so rdy is not trusted here.
      ARM:    state_next = BUSY;
      BUSY: begin
        if (bus.spi_rdy) begin
          rx_next              = bus.spi_rx;
          done_next[owner_reg] = 1'b1;
          state_next           = READY;
        end
      end
      HOLD: begin
        if (cnt_reg == HOLD_LAST) state_next = GAP;
        else cnt_next = cnt_reg + 8'd1;
      end
      GAP: begin
        pri_next   = ~owner_reg;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  assign gnt_active = (state_reg == READY) || (state_reg == LAUNCH) ||
                      (state_reg == ARM)   || (state_reg == BUSY);
  assign cs_active  = (state_reg != IDLE) && (state_reg != GAP);

  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_dev
      assign bus.gnt[gi]  = gnt_active && (owner_reg == 1'(gi));
      assign bus.cs_n[gi] = !(cs_active && (owner_reg == 1'(gi)));
    end
  endgenerate

  assign bus.done      = done_reg;
  assign bus.err       = err_reg;
  assign bus.rx        = rx_reg;
  assign bus.spi_start = (state_reg == LAUNCH);
  assign bus.spi_fast  = fast_reg;
  assign bus.spi_tx    = tx_reg;

endmodule

// File: doc/spi_arbiter.md
Name: spi_arbiter

Overview:
- Shares one SPI transfer engine between two requesters, e.g. SD card (0) and SPI flash (1); the engine runs word/fast or byte/slow transfers with a start/rdy handshake.
- Owns per-device active-low chip selects and CS setup/hold timing.
- Round-robin grant per burst: CS stays asserted across back-to-back transfers until the owner drops req.
- Sits between the I/O register decode and the existing SPI engine.

Parameters:
CS_SETUP, 4, cycles CS asserted before first transfer may launch (1..255)
CS_HOLD, 4, cycles CS held after burst ends before release (1..255)
WDOG_CYCLES, 1024, idle-grant timeout (used only with SPI_ARB_WDOG_EN)

Ports:
clk  in  1  system clock
rst  in  1  synchronous reset, active-high
req  in  2  per requester: level, hold high for whole burst
xfer  in  2  per requester: 1-cycle strobe launching one transfer, honoured only in READY for the granted owner
fast  in  2  per requester: mode for its transfers (1=32-bit fast, 0=8-bit slow)
tx0  in  32  requester 0 transmit data, sampled on accepted xfer
tx1  in  32  requester 1 transmit data
gnt  out  2  one-hot grant; high only in READY/LAUNCH/ARM/BUSY for owner
done  out  2  1-cycle pulse to owner when transfer completes
rx  out  32  last received data, shared, valid from done pulse onward
err  out  2  1-cycle watchdog revoke pulse (tied 0 without macro)
cs_n  out  2  active-low chip selects, at most one low
spi_start  out  1  engine start pulse
spi_fast  out  1  engine mode
spi_tx  out  32  engine transmit data
spi_rdy  in  1  engine ready
spi_rx  in  32  engine receive data

Behaviour:
- Reset (rst=1 at edge): state IDLE; gnt=0, done=0, err=0, spi_start=0, spi_fast=0, spi_tx=0, rx=0, cs_n=2'b11, rr pointer favours requester 0. Reset mid-burst drops CS next cycle, no done.
- States: IDLE, SETUP, READY, LAUNCH, ARM, BUSY, HOLD, GAP.
- IDLE: if any req, pick owner: single requester wins; both -> the one not last granted (first after reset: 0). Next cycle SETUP, cs_n[owner]=0.
- SETUP: count CS_SETUP cycles, then READY. gnt[owner] rises CS_SETUP+1 cycles after the req-sampling edge.
- READY: xfer[owner]=1 -> register spi_tx=tx_owner, spi_fast=fast[owner]; go LAUNCH. Else req[owner]=0 -> HOLD. xfer takes priority when it coincides with req drop.
- LAUNCH: spi_start=1 for exactly this cycle; go ARM.
- ARM: one cycle ignoring spi_rdy, since the engine drops rdy one cycle after start. Go BUSY.
- BUSY: wait spi_rdy=1; on that edge rx<=spi_rx (full 32 bits; engine zero-extends slow bytes), done[owner]=1 next cycle, back to READY. req drop while BUSY does not abort; the transfer finishes, then HOLD.
- HOLD: CS still low, gnt=0, count CS_HOLD cycles, then GAP.
- GAP: cs_n=2'b11 for exactly 1 cycle; update rr pointer; go IDLE. Guarantees ≥1 cycle with both CS high between owners.
- xfer from non-owner, or in any state other than READY: ignored, no queueing, no done.
- spi_fast/spi_tx hold value between transfers; mode switch only per transfer.
- Latency xfer->spi_start: 1 cycle. spi_rdy high -> done: 1 cycle.

Optional Feature:
- Macro SPI_ARB_WDOG_EN.
- Defined: counter reset on entering READY and on each accepted xfer. If it reaches WDOG_CYCLES while in READY, err[owner] pulses 1 cycle and the block goes to HOLD as if req dropped. Owner must drop and reassert req for a new grant.
- Undefined: no counter, err=2'b00 constantly, WDOG_CYCLES unused.

Test Plan:
- Bench setup: real engine, MOSI looped to MISO. req=01, CS_SETUP=4 -> cs_n=10 next cycle, gnt=01 after 5 cycles; xfer0, fast0=0, tx0=0x000000A5 -> spi_start 1 cycle later, done=01, rx=0x000000A5.
- Fast word: fast0=1, tx0=0x12345678 -> rx=0x12345678; two back-to-back xfers keep cs_n[0]=0 throughout; req drop -> CS high after CS_HOLD+1 cycles.
- Contention: req=11 same cycle after reset -> owner 0 first; during 0's burst cs_n[1]=1; 0 releases -> GAP shows cs_n=11 one cycle, then owner 1 (SETUP); next contention grants 0 only if 1 last.
- Illegal strobes: xfer1 while owner=0, xfer0 during BUSY -> no spi_start, no done, rx unchanged.
- rst=1 during BUSY -> next cycle cs_n=11, gnt=00, no done; after release req=10 granted normally.
- SPI_ARB_WDOG_EN, WDOG_CYCLES=16: grant, no xfer -> err[0] pulse after 16 READY cycles, then HOLD/GAP; without macro err stays 00 and grant persists.
